mips_register_file: RTL and testbench
=====================================

// Module: mips_register_file
// PURPOSE
//   General-purpose register file of the single-cycle MIPS datapath: 32 registers x 32 bits.
//   - Two independent combinational read ports feed the ALU operands.
//   - One synchronous write port takes the write-back result.
//   - Register $0 is hardwired to zero, per the MIPS ISA.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and of the data ports
//   ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH (32)
// PORTS
//   clock            in   1           system clock; all state changes on rising edge
//   reset            in   1           synchronous, active-high; clears every register
//   reg_write        in   1           write enable for the write port
//   read_register_1  in   ADDR_WIDTH  index for read port 1
//   read_register_2  in   ADDR_WIDTH  index for read port 2
//   write_register   in   ADDR_WIDTH  index for the write port
//   write_data       in   DATA_WIDTH  data written when reg_write=1
//   read_data_1      out  DATA_WIDTH  contents of register read_register_1
//   read_data_2      out  DATA_WIDTH  contents of register read_register_2
// BEHAVIOUR
// - Reset (synchronous)
//   - One clock, one synchronous active-high reset.
//   - Rising edge with reset=1: all 32 registers <= 0.
//   - Reset has priority over reg_write; a write in the same cycle is dropped.
//   - Before the first reset edge, register contents are undefined (X in simulation).
//   - After that edge, both read outputs return 0 for every index.
// - Write
//   - Rising edge with reset=0 and reg_write=1: reg[write_register] <= write_data.
//   - reg_write=0: no register changes.
// - Register $0
//   - Writes to index 0 are silently discarded.
//   - read_data_* for index 0 is always 32'h0, before reset, after reset and after any write.
// - Read
//   - Purely combinational, zero-cycle latency, no clock involvement.
//   - Outputs follow their address inputs and the array contents immediately.
//   - Both ports may address the same register, or the write index, with no conflict.
// - Read/write same index, same cycle
//   - No internal forwarding: before the edge the read port shows the old value.
//   - The new value appears right after the rising edge.
//   - The datapath handles write-back timing externally.
// - Widths
//   - Index inputs are exactly ADDR_WIDTH bits, so every index is valid; no out-of-range case exists.
//   - write_data is stored unmodified (no sign/zero handling).
// - Structure
//   - No handshake, no stall, no state machine.
//   - Only the array of 31 writable registers plus the $0 constant.
// TESTING
// 1. Reset: pulse reset=1 over one rising edge, reg_write=0
//    -> read_data_1/2 = 0 for all indices 0..31.
// 2. Sweep write: each cycle i=0..31 set write_register=i, write_data=3*i+1, reg_write=1,
//    read_register_2=i, read_register_1=(i+31)%32
//    -> after edge: read_data_2=3*i+1 (i>0), read_data_1=3*(i-1)+1 for i>=2, 0 for i=1.
//    -> read_data_2 stays 0 for i=0.
// 3. $0 protection: write 32'hDEADBEEF to index 0 with reg_write=1
//    -> read_data_1 and read_data_2 at index 0 remain 32'h0.
// 4. Write enable off: after sweep, reg_write=0, write_register=5, write_data=32'hFFFFFFFF, one edge
//    -> register 5 still reads 16.
// 5. Same-index read/write: read_register_1=7 (holds 22), write 32'h12345678 to 7
//    -> read_data_1=22 before the edge, 32'h12345678 after it.
// 6. Reset mid-operation: reset=1 and reg_write=1 (index 3, data 99) on the same edge
//    -> all registers 0, including index 3.

Source files
------------

// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: 32 x 32-bit, two combinational read
// ports, one synchronous write port, register $0 hardwired to zero.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 exists only to keep indexing uniform; it is never written with
  // anything but zero, and the read mux forces zero for index 0 regardless,
  // so $0 reads as zero even before the first reset edge.
  logic [DATA_WIDTH-1:0] r_regs [0:DEPTH-1];

  logic                  w_write_en;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  // True when the index names one of the writable registers ($1..$31).
  function automatic logic is_writable(input logic [ADDR_WIDTH-1:0] idx);
    return (idx != {ADDR_WIDTH{1'b0}});
  endfunction

  assign w_write_en = reg_write & is_writable(write_register);

  // Register array update: reset clears everything and drops any same-cycle
  // write; otherwise store write_data unmodified into a writable register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_write_en) begin
      r_regs[write_register] <= write_data;
    end else begin
      r_regs[write_register] <= r_regs[write_register];
    end
  end

  // Combinational read ports; no forwarding, so a same-cycle write becomes
  // visible only after the clock edge.
  always_comb begin
    w_rd1 = {DATA_WIDTH{1'b0}};
    w_rd2 = {DATA_WIDTH{1'b0}};
    if (is_writable(read_register_1)) begin
      w_rd1 = r_regs[read_register_1];
    end else begin
      w_rd1 = {DATA_WIDTH{1'b0}};
    end
    if (is_writable(read_register_2)) begin
      w_rd2 = r_regs[read_register_2];
    end else begin
      w_rd2 = {DATA_WIDTH{1'b0}};
    end
  end

  assign read_data_1 = w_rd1;
  assign read_data_2 = w_rd2;

endmodule

// File: tb/tb_mips_register_file.sv
// Directed, table-driven bench for mips_register_file.
module tb_mips_register_file;

  logic        clock;
  logic        reset;
  logic        reg_write;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs [NVEC];

  mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock           (clock),
    .reset           (reset),
    .reg_write       (reg_write),
    .read_register_1 (read_register_1),
    .read_register_2 (read_register_2),
    .write_register  (write_register),
    .write_data      (write_data),
    .read_data_1     (read_data_1),
    .read_data_2     (read_data_2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read every index on both ports (no clock edge) and compare with a model.
  task automatic check_all(input string name, input logic [31:0] model [32]);
    reg_write = 1'b0;
    reset     = 1'b0;
    for (int k = 0; k < 32; k++) begin
      read_register_1 = 5'(k);
      read_register_2 = 5'(31 - k);
      #1;
      check($sformatf("%s rd1[%0d]", name, k), read_data_1, model[k]);
      check($sformatf("%s rd2[%0d]", name, 31 - k), read_data_2, model[31 - k]);
    end
  endtask

  initial begin
    logic [31:0] zeros [32];
    total = 0;
    bad   = 0;
    for (int k = 0; k < 32; k++) zeros[k] = 32'h0;

    // Vector table: sweep writes, $0 protection, write-enable off.
    for (int i = 0; i < 32; i++) begin
      vecs[i].rst = 1'b0;
      vecs[i].we  = 1'b1;
      vecs[i].wr  = 5'(i);
      vecs[i].wd  = 32'(3 * i + 1);
      vecs[i].rr2 = 5'(i);
      vecs[i].rr1 = 5'((i + 31) % 32);
      vecs[i].e2  = (i == 0) ? 32'h0 : 32'(3 * i + 1);
      vecs[i].e1  = (i >= 2) ? 32'(3 * (i - 1) + 1) : 32'h0;
    end
    vecs[32] = '{rst: 1'b0, we: 1'b1, rr1: 5'd0, rr2: 5'd0, wr: 5'd0,
                 wd: 32'hDEADBEEF, e1: 32'h0, e2: 32'h0};
    vecs[33] = '{rst: 1'b0, we: 1'b0, rr1: 5'd5, rr2: 5'd5, wr: 5'd5,
                 wd: 32'hFFFFFFFF, e1: 32'd16, e2: 32'd16};

    reset = 1'b0; reg_write = 1'b0;
    read_register_1 = 5'd0; read_register_2 = 5'd0;
    write_register = 5'd0; write_data = 32'h0;
    #2;
    // $0 reads zero before any reset.
    check("pre-reset r0 rd1", read_data_1, 32'h0);
    check("pre-reset r0 rd2", read_data_2, 32'h0);

    // Test 1: reset pulse over one edge.
    reset = 1'b1;
    @(posedge clock); #1;
    check_all("reset", zeros);

    // Tests 2-4: table-driven.
    for (int v = 0; v < NVEC; v++) begin
      reset           = vecs[v].rst;
      reg_write       = vecs[v].we;
      read_register_1 = vecs[v].rr1;
      read_register_2 = vecs[v].rr2;
      write_register  = vecs[v].wr;
      write_data      = vecs[v].wd;
      @(posedge clock); #1;
      check($sformatf("vec%0d rd1", v), read_data_1, vecs[v].e1);
      check($sformatf("vec%0d rd2", v), read_data_2, vecs[v].e2);
    end

    // Test 5: same-index read/write, no forwarding.
    reg_write = 1'b1; write_register = 5'd7; write_data = 32'h12345678;
    read_register_1 = 5'd7; read_register_2 = 5'd7;
    #1;
    check("same-idx before rd1", read_data_1, 32'd22);
    check("same-idx before rd2", read_data_2, 32'd22);
    @(posedge clock); #1;
    check("same-idx after rd1", read_data_1, 32'h12345678);
    check("same-idx after rd2", read_data_2, 32'h12345678);

    // Test 6: reset beats a same-cycle write.
    reg_write = 1'b0; read_register_1 = 5'd3; read_register_2 = 5'd31;
    #1;
    check("pre-midreset r3", read_data_1, 32'd10);
    check("pre-midreset r31", read_data_2, 32'd94);
    reset = 1'b1; reg_write = 1'b1; write_register = 5'd3; write_data = 32'd99;
    @(posedge clock); #1;
    check_all("midreset", zeros);

    // A plain write after reset works again.
    reg_write = 1'b1; write_register = 5'd3; write_data = 32'd99;
    read_register_1 = 5'd3; read_register_2 = 5'd4;
    @(posedge clock); #1;
    check("post-reset write r3", read_data_1, 32'd99);
    check("post-reset r4", read_data_2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
